// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant lasts up to MAX_BURST beats and always passes through IDLE before the next grant.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                  found;
  logic [IDW-1:0]        pick;
  logic [IDW:0]          idx_sum;
  logic [IDW-1:0]        grant_nxt;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from the highest rr offset down so the nearest valid requester wins.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    idx_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (idx_sum >= (IDW+1)'(NUM_REQ)) begin
        idx_sum = idx_sum - (IDW+1)'(NUM_REQ);
      end
      if (req_valid[idx_sum[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx_sum[IDW-1:0];
      end
    end
  end

  assign grant_nxt = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
  assign grant_id  = grant_id_q;

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    grant_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BURST;
          grant_id_d = pick;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        grant_valid           = 1'b1;
        req_ready[grant_id_q] = ~fifo_full;
        fifo_wr_data          = data_arr[grant_id_q];
        fifo_wr_en            = req_valid[grant_id_q] & ~fifo_full;
        if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end
        // A dropped valid ends the burst even while the FIFO is full.
        if (!req_valid[grant_id_q] ||
            (fifo_wr_en && (beat_cnt_q == BCW'(MAX_BURST - 1)))) begin
          state_d  = IDLE;
          rr_ptr_d = grant_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: producers push presented words into a
// per-requester scoreboard; a negedge monitor checks writes against an rr reference model.
module tb_fifo_wr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IDW = 2;
  localparam int SBD = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb_mem [N][SBD];
  int            sb_wr  [N] = '{default: 0};
  int            sb_rd  [N] = '{default: 0};

  int           gen_en, p_new, p_cont, p_full;
  logic [N-1:0] gen_mask;

  int           mon_gv, mon_beats, last_g, rr_m, prev_gv;
  logic [N-1:0] prev_valid;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  // One clock of producer behaviour: hold an unaccepted word, otherwise maybe offer a new one.
  task automatic step();
    logic [N-1:0]  hs;
    logic [DW-1:0] d;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !hs[i]) continue;
      if (gen_en != 0 && gen_mask[i] &&
          $urandom_range(99) < (hs[i] ? p_cont : p_new)) begin
        d = DW'($urandom);
        sb_mem[i][sb_wr[i] % SBD] = d;
        sb_wr[i]++;
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = d;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    fifo_full = ($urandom_range(99) < p_full);
  endtask

  task automatic phase(input int cycles, input logic [N-1:0] mask,
                       input int pn, input int pc, input int pf);
    gen_en = 1; gen_mask = mask; p_new = pn; p_cont = pc; p_full = pf;
    for (int c = 0; c < cycles; c++) step();
  endtask

  always @(negedge clk) begin
    int exp_wr;
    if (!rst_n) begin
      prev_gv = 0; prev_valid = '0; last_g = 0; rr_m = 0; mon_beats = 0; mon_gv = 0;
    end else begin
      if (prev_gv != 0) begin
        mon_gv = (!prev_valid[last_g] || mon_beats == MB) ? 0 : 1;
        if (mon_gv == 0) rr_m = (last_g + 1) % N;
      end else begin
        mon_gv = (prev_valid != '0) ? 1 : 0;
        if (mon_gv != 0) begin
          last_g    = rr_pick(prev_valid, rr_m);
          mon_beats = 0;
        end
      end
      chk("grant_valid", grant_valid, mon_gv);
      chk("grant_id", grant_id, last_g);
      exp_wr = (mon_gv != 0 && req_valid[last_g] && !fifo_full) ? 1 : 0;
      chk("wr_en", fifo_wr_en, exp_wr);
      chk("req_ready", req_ready, (mon_gv != 0 && !fifo_full) ? (1 << last_g) : 0);
      if (exp_wr != 0) begin
        if (sb_rd[last_g] == sb_wr[last_g]) begin
          total++; bad++;
          $display("FAIL sb_empty: write for req %0d data=%0h with nothing expected", last_g, fifo_wr_data);
        end else begin
          chk("wr_data", fifo_wr_data, sb_mem[last_g][sb_rd[last_g] % SBD]);
          sb_rd[last_g]++;
        end
        mon_beats++;
      end else if (mon_gv == 0) begin
        chk("idle_data", fifo_wr_data, 0);
      end
      prev_gv    = mon_gv;
      prev_valid = req_valid;
    end
  end

  initial begin
    bit hit;
    req_valid = '0; req_data = '0; fifo_full = 1'b0; rst_n = 1'b0;
    gen_en = 1; gen_mask = '1; p_new = 100; p_cont = 100; p_full = 0;

    step(); step();
    #2;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_data", fifo_wr_data, 0);
    rst_n = 1'b1;

    phase(120, 4'b1111, 100, 100, 0);
    phase(80,  4'b0100, 100, 50,  0);
    phase(80,  4'b1001, 100, 80,  0);
    phase(500, 4'b1111, 40,  70,  30);
    phase(200, 4'b1111, 60,  60,  10);

    p_full = 0; p_cont = 100; p_new = 50; gen_mask = '1;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      step();
      if (mon_gv != 0 && mon_beats == 2) hit = 1'b1;
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL mid_burst_wait: got=timeout want=beat2");
    end else begin
      #2;
      chk("pre_rst_wr_en", fifo_wr_en, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_en", fifo_wr_en, 0);
      chk("mid_rst_gv", grant_valid, 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_gid", grant_id, 0);
      step(); step();
      rst_n = 1'b1;
    end

    phase(300, 4'b1111, 50, 70, 20);

    gen_en = 0; p_full = 10;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      step();
      if (req_valid == '0) hit = 1'b1;
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL drain: got=valid_%0b want=all_idle", req_valid);
    end
    step();
    for (int i = 0; i < N; i++) chk("sb_left", sb_wr[i] - sb_rd[i], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
